// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_driver
// Function : Two 50 Hz servo PWM channels driven by SPI pan/tilt commands,
//            with a command timeout that returns the servos to centre.
//            Define SERVO_SLEW_EN to limit per-frame movement to SLEW_MAX
//            LSBs; otherwise the applied position jumps to the target.
// Revision : 1.0
// ============================================================================
module servo_pwm_driver #(
  parameter int unsigned PERIOD_CYC     = 500000,
  parameter int unsigned MIN_PULSE_CYC  = 25000,
  parameter int unsigned STEP_X_CYC     = 98,
  parameter int unsigned STEP_Y_CYC     = 196,
  parameter int unsigned SLEW_MAX       = 4,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mosi_valid,
  input  logic [7:0] mortor_xdata,
  input  logic [6:0] mortor_ydata,
  input  logic       en,
  output logic       pwm_x,
  output logic       pwm_y,
  output logic       frame_tick,
  output logic       stale,
  output logic [7:0] cur_x,
  output logic [6:0] cur_y
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
  localparam int unsigned WID_W = $clog2(PERIOD_CYC + 1);
  localparam int unsigned NV_W  = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [7:0]       CENTRE_X = 8'd128;
  localparam logic [6:0]       CENTRE_Y = 7'd64;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [NV_W-1:0]  NV_LIMIT = NV_W'(TIMEOUT_FRAMES);

  if ((MIN_PULSE_CYC + 255 * STEP_X_CYC >= PERIOD_CYC) ||
      (MIN_PULSE_CYC + 127 * STEP_Y_CYC >= PERIOD_CYC)) begin : g_width_check
    $error("servo_pwm_driver: full-scale pulse does not fit in PERIOD_CYC");
  end

  function automatic logic [WID_W-1:0] width_of(input int unsigned pos,
                                                input int unsigned step);
    return WID_W'(MIN_PULSE_CYC + pos * step);
  endfunction

  // Moves cur toward tgt by at most SLEW_MAX without overshooting.
  function automatic int unsigned step_toward(input int unsigned cur,
                                              input int unsigned tgt);
    if (tgt >= cur) return (tgt - cur <= SLEW_MAX) ? tgt : cur + SLEW_MAX;
    return (cur - tgt <= SLEW_MAX) ? tgt : cur - SLEW_MAX;
  endfunction

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [7:0]       tgt_x_q,   tgt_x_d,   cur_x_q,   cur_x_d;
  logic [6:0]       tgt_y_q,   tgt_y_d,   cur_y_q,   cur_y_d;
  logic [WID_W-1:0] width_x_q, width_x_d, width_y_q, width_y_d;
  logic [NV_W-1:0]  nv_cnt_q,  nv_cnt_d;
  logic             stale_q,   stale_d;
  logic             en_q,      en_d;
  logic             pwm_x_q,   pwm_x_d,   pwm_y_q,   pwm_y_d;
  logic             tick_q,    tick_d;
  logic             frame_end;
  logic [7:0]       cur_x_next;
  logic [6:0]       cur_y_next;

`ifdef SERVO_SLEW_EN
  assign cur_x_next = 8'(step_toward(32'(cur_x_q), 32'(tgt_x_q)));
  assign cur_y_next = 7'(step_toward(32'(cur_y_q), 32'(tgt_y_q)));
`else
  assign cur_x_next = tgt_x_q;
  assign cur_y_next = tgt_y_q;
`endif

  always_comb begin
    frame_end = (cnt_q == CNT_LAST);
    cnt_d     = frame_end ? '0 : cnt_q + CNT_W'(1);
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    width_x_d = width_x_q;
    width_y_d = width_y_q;
    nv_cnt_d  = nv_cnt_q;
    stale_d   = stale_q;
    en_d      = en_q;

    if (frame_end) begin
      cur_x_d   = cur_x_next;
      cur_y_d   = cur_y_next;
      width_x_d = width_of(32'(cur_x_next), STEP_X_CYC);
      width_y_d = width_of(32'(cur_y_next), STEP_Y_CYC);
      en_d      = en;
      if (!mosi_valid) begin
        if (nv_cnt_q != NV_LIMIT) nv_cnt_d = nv_cnt_q + NV_W'(1);
        if (nv_cnt_d == NV_LIMIT) begin
          tgt_x_d = CENTRE_X;
          tgt_y_d = CENTRE_Y;
          stale_d = 1'b1;
        end
      end
    end

    // A strobe overrides any timeout decided in the same cycle.
    if (mosi_valid) begin
      tgt_x_d  = mortor_xdata;
      tgt_y_d  = mortor_ydata;
      nv_cnt_d = '0;
      stale_d  = 1'b0;
    end

    pwm_x_d = en_q && (WID_W'(cnt_q) < width_x_q);
    pwm_y_d = en_q && (WID_W'(cnt_q) < width_y_q);
    tick_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      tgt_x_q   <= CENTRE_X;
      tgt_y_q   <= CENTRE_Y;
      cur_x_q   <= CENTRE_X;
      cur_y_q   <= CENTRE_Y;
      width_x_q <= width_of(32'(CENTRE_X), STEP_X_CYC);
      width_y_q <= width_of(32'(CENTRE_Y), STEP_Y_CYC);
      nv_cnt_q  <= '0;
      stale_q   <= 1'b1;
      en_q      <= 1'b0;
      pwm_x_q   <= 1'b0;
      pwm_y_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      width_x_q <= width_x_d;
      width_y_q <= width_y_d;
      nv_cnt_q  <= nv_cnt_d;
      stale_q   <= stale_d;
      en_q      <= en_d;
      pwm_x_q   <= pwm_x_d;
      pwm_y_q   <= pwm_y_d;
      tick_q    <= tick_d;
    end
  end

  assign pwm_x      = pwm_x_q;
  assign pwm_y      = pwm_y_q;
  assign frame_tick = tick_q;
  assign stale      = stale_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_driver
// Function : Frame-level scoreboard bench for servo_pwm_driver.
// Revision : 1.0
// ============================================================================
module tb_servo_pwm_driver;

  localparam int PERIOD = 1000;
  localparam int MINP   = 50;
  localparam int SX     = 1;
  localparam int SY     = 2;
  localparam int SLEW   = 8;
  localparam int TO     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mosi_valid = 1'b0;
  logic [7:0] xd = '0;
  logic [6:0] yd = '0;
  logic       en = 1'b0;
  logic       pwm_x, pwm_y, frame_tick, stale;
  logic [7:0] cur_x;
  logic [6:0] cur_y;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int wx; int wy; int cx; int cy; int st; int tick0;
  } exp_t;
  exp_t sb[$];

  int m_tgt_x, m_tgt_y, m_cur_x, m_cur_y, m_nv, m_stale, m_en, m_tick0;

  servo_pwm_driver #(
    .PERIOD_CYC(PERIOD), .MIN_PULSE_CYC(MINP), .STEP_X_CYC(SX),
    .STEP_Y_CYC(SY), .SLEW_MAX(SLEW), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .reset(reset), .mosi_valid(mosi_valid),
    .mortor_xdata(xd), .mortor_ydata(yd), .en(en),
    .pwm_x(pwm_x), .pwm_y(pwm_y), .frame_tick(frame_tick), .stale(stale),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step(int cur, int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt > cur + SLEW) return cur + SLEW;
    if (cur > tgt + SLEW) return cur - SLEW;
`endif
    return tgt;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.wx    = m_en ? MINP + SX * m_cur_x : 0;
    e.wy    = m_en ? MINP + SY * m_cur_y : 0;
    e.cx    = m_cur_x;
    e.cy    = m_cur_y;
    e.st    = m_stale;
    e.tick0 = m_tick0;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_tgt_x = 128; m_tgt_y = 64; m_cur_x = 128; m_cur_y = 64;
    m_nv = 0; m_stale = 1; m_en = 0; m_tick0 = 0;
    push_expect();
  endtask

  task automatic boundary(input bit v_end, input int x, input int y);
    m_cur_x = step(m_cur_x, m_tgt_x);
    m_cur_y = step(m_cur_y, m_tgt_y);
    m_en    = en;
    m_tick0 = 1;
    if (v_end) begin
      m_tgt_x = x; m_tgt_y = y; m_nv = 0; m_stale = 0;
    end else begin
      if (m_nv < TO) m_nv++;
      if (m_nv == TO) begin
        m_tgt_x = 128; m_tgt_y = 64; m_stale = 1;
      end
    end
    push_expect();
  endtask

  // Runs one full frame starting at the negedge of the cnt==0 cycle.
  task automatic frame(input bit v_mid, input logic [7:0] x, input logic [6:0] y,
                       input bit v_end, input bit en_new, input int en_at);
    exp_t e;
    int   hx = 0;
    int   hy = 0;
    int   t0 = 0;
    int   t_other = 0;
    bit   en_old = en;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{default: -1};
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 0) begin
        chk("cur_x", cur_x, e.cx);
        chk("cur_y", cur_y, e.cy);
        chk("stale", stale, e.st);
      end
      if (c == 500) chk("stale_mid", stale, m_stale);
      hx += int'(pwm_x);
      hy += int'(pwm_y);
      if (frame_tick) begin
        if (c == 0) t0 = 1;
        else t_other++;
      end
      en = (c >= en_at) ? en_new : en_old;
      if ((v_mid && c == 10) || (v_end && c == PERIOD - 1)) begin
        mosi_valid = 1'b1; xd = x; yd = y;
      end else begin
        mosi_valid = 1'b0; xd = 8'($urandom); yd = 7'($urandom);
      end
      if (v_mid && c == 10) begin
        m_tgt_x = x; m_tgt_y = y; m_nv = 0; m_stale = 0;
      end
      if (c == PERIOD - 1) boundary(v_end, x, y);
      @(negedge clk);
    end
    chk("width_x", hx, e.wx);
    chk("width_y", hy, e.wy);
    chk("tick_at0", t0, e.tick0);
    chk("tick_extra", t_other, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 8'd0, 7'd0, 1'b0, 1'b1, 0);
  endtask

  initial begin
    model_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm_x", pwm_x, 0);
    chk("rst_pwm_y", pwm_y, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_stale", stale, 1);
    chk("rst_cur_x", cur_x, 128);
    chk("rst_cur_y", cur_y, 64);
    reset = 1'b0;

    idle(2);
    for (int i = 0; i < 9; i++)  frame(1'b1, 8'd200, 7'd100, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) frame(1'b1, 8'd255, 7'd127, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++)  frame(1'b1, 8'd0,   7'd0,   1'b0, 1'b1, 0);

    frame(1'b1, 8'd10, 7'd10, 1'b0, 1'b1, 0);
    idle(4);

    frame(1'b1, 8'd30, 7'd20, 1'b0, 1'b1, 0);
    idle(1);
    frame(1'b0, 8'd30, 7'd20, 1'b1, 1'b1, 0);
    idle(2);

    frame(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 100);
    frame(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 0);
    frame(1'b0, 8'd0, 7'd0, 1'b0, 1'b1, 100);
    idle(2);

    repeat (20) @(negedge clk);
    chk("pre_rst_pwm_x", pwm_x, (sb.size() > 0 && sb[0].wx > 20) ? 1 : 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm_x", pwm_x, 0);
    chk("mid_rst_pwm_y", pwm_y, 0);
    chk("mid_rst_stale", stale, 1);
    chk("mid_rst_cur_x", cur_x, 128);
    sb.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
